// File: rtl/pwl_share_arb_pkg.sv
// Shared types and helpers for the pwl sharing arbiter: requester id type,
// statistics width and the mask-based round-robin picker.
package pwl_share_arb_pkg;

    localparam int N_REQ_MAX  = 16;
    localparam int STAT_WIDTH = 16;

    typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;
    typedef logic [N_REQ_MAX-1:0]         req_vec_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } rr_pick_t;

    // Lowest valid bit at or above ptr wins; otherwise wrap to the lowest valid bit overall.
    function automatic rr_pick_t rr_pick(input req_vec_t valid, input req_id_t ptr);
        req_vec_t upper;
        rr_pick_t pick;
        upper = valid & ~((req_vec_t'(1) << ptr) - req_vec_t'(1));
        pick  = '0;
        for (int i = N_REQ_MAX - 1; i >= 0; i--) begin
            if (valid[i]) begin
                pick.found = 1'b1;
                pick.id    = req_id_t'(i);
            end
        end
        for (int i = N_REQ_MAX - 1; i >= 0; i--) begin
            if (upper[i]) begin
                pick.id = req_id_t'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pwl_share_fifo.sv
// Synchronous response FIFO with occupancy count; push and pop may coincide
// at any fill level, including full.
module pwl_share_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             doPop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rdPtr_q];
    assign doPop      = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(doPop);
        end
    end

    noOverflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full && !doPop));

endmodule

// File: rtl/pwl_share_arb.sv
// Round-robin sharing of one pwl evaluator among N_REQ requesters with a
// credit-protected response FIFO. Optional counters under PWL_SHARE_ARB_STATS_EN.
module pwl_share_arb
    import pwl_share_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int IN_WIDTH      = 16,
    parameter int SETTING_WIDTH = 4,
    parameter int OUT_WIDTH     = 18,
    parameter int PWL_LATENCY   = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ*IN_WIDTH-1:0]        req_in_i,
    input  logic [N_REQ*SETTING_WIDTH-1:0]   req_setting_i,
    output logic [IN_WIDTH-1:0]              pwl_in_o,
    output logic [SETTING_WIDTH-1:0]         pwl_setting_o,
    input  logic signed [OUT_WIDTH-1:0]      pwl_out_i,
    output logic                             resp_valid_o,
    input  logic                             resp_ready_i,
    output logic [$clog2(N_REQ)-1:0]         resp_id_o,
    output logic signed [OUT_WIDTH-1:0]      resp_data_o
`ifdef PWL_SHARE_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_WIDTH-1:0]      stat_grants_o,
    output logic [STAT_WIDTH-1:0]            stat_stall_o
`endif
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = ID_W + OUT_WIDTH;

    logic [ID_W-1:0]          rrPtr_q;
    logic [ID_W-1:0]          rrPtr_d;
    logic [IN_WIDTH-1:0]      lastIn_q;
    logic [SETTING_WIDTH-1:0] lastSetting_q;
    logic                     tagValid_q [PWL_LATENCY];
    logic [ID_W-1:0]          tagId_q    [PWL_LATENCY];

    rr_pick_t                 pick;
    logic                     grantValid;
    logic [ID_W-1:0]          grantId;
    logic                     credit;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         fifoCount;
    logic                     fifoEmpty;
    logic                     popEn;
    logic                     pushEn;
    logic [ENTRY_W-1:0]       headEntry;

    assign popEn  = resp_ready_i & ~fifoEmpty;
    assign pushEn = tagValid_q[PWL_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int k = 0; k < PWL_LATENCY; k++) begin
            inflight = inflight + CNT_W'(tagValid_q[k]);
        end
    end

    // A same-cycle pop frees its slot, so a full FIFO can still grant while draining.
    assign credit = (SUM_W'(fifoCount) + SUM_W'(inflight)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(popEn));

    always_comb begin
        pick          = rr_pick(req_vec_t'(req_valid_i), req_id_t'(rrPtr_q));
        grantValid    = pick.found & credit & ~rst;
        grantId       = ID_W'(pick.id);
        req_ready_o   = '0;
        pwl_in_o      = lastIn_q;
        pwl_setting_o = lastSetting_q;
        rrPtr_d       = rrPtr_q;
        if (grantValid) begin
            req_ready_o[grantId] = 1'b1;
            pwl_in_o      = req_in_i[grantId*IN_WIDTH +: IN_WIDTH];
            pwl_setting_o = req_setting_i[grantId*SETTING_WIDTH +: SETTING_WIDTH];
            rrPtr_d       = (grantId == ID_W'(N_REQ - 1)) ? '0 : grantId + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q       <= '0;
            lastIn_q      <= '0;
            lastSetting_q <= '0;
            for (int k = 0; k < PWL_LATENCY; k++) begin
                tagValid_q[k] <= 1'b0;
                tagId_q[k]    <= '0;
            end
        end else begin
            rrPtr_q <= rrPtr_d;
            if (grantValid) begin
                lastIn_q      <= pwl_in_o;
                lastSetting_q <= pwl_setting_o;
            end
            tagValid_q[0] <= grantValid;
            tagId_q[0]    <= grantId;
            for (int k = 1; k < PWL_LATENCY; k++) begin
                tagValid_q[k] <= tagValid_q[k-1];
                tagId_q[k]    <= tagId_q[k-1];
            end
        end
    end

    pwl_share_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pushEn),
        .push_data_i ({tagId_q[PWL_LATENCY-1], pwl_out_i}),
        .pop_i       (popEn),
        .pop_data_o  (headEntry),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    assign resp_valid_o = ~fifoEmpty;
    assign resp_id_o    = fifoEmpty ? '0 : headEntry[ENTRY_W-1 -: ID_W];
    assign resp_data_o  = fifoEmpty ? '0 : headEntry[OUT_WIDTH-1:0];

    grantOneHot: assert property (@(posedge clk) $onehot0(req_ready_o));

`ifdef PWL_SHARE_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grantCnt_q [N_REQ];
    logic [STAT_WIDTH-1:0] stallCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                grantCnt_q[i] <= '0;
            end
        end else begin
            if ((|req_valid_i) && !credit && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grantValid && (grantId == ID_W'(i)) && (grantCnt_q[i] != '1)) begin
                    grantCnt_q[i] <= grantCnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_grants_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_grants_o[i*STAT_WIDTH +: STAT_WIDTH] = grantCnt_q[i];
        end
    end

    assign stat_stall_o = stallCnt_q;
`endif

endmodule
